// File: rtl/sram_responder.sv
// sram_responder: on-chip block-RAM stand-in for a 16-bit async SRAM, driven from an initiator's pins.
// Latency: pin-to-read-data SYNC_STAGES+1 clocks; a write commits SYNC_STAGES+1 clocks after the WE rising edge.
// Backpressure: none; the initiator must hold each pin phase for at least SYNC_STAGES+2 clocks.
//
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   sram_addr/data_in   address and write-data pins from the initiator
//   sram_cs/oe/we       active-low chip select, output enable, write enable
//   sram_data_out/oe    read data toward the initiator and its tri-state enable
//   wr_count/rd_count   saturating counts of committed writes and read entries
//   conflict            sticky flag: CS, OE and WE seen low together
module sram_responder #(
   parameter int AW          = 18,
   parameter int DW          = 16,
   parameter int MEM_AW      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] sram_addr,
   input  logic [DW-1:0] sram_data_in,
   input  logic          sram_cs,
   input  logic          sram_oe,
   input  logic          sram_we,
   output logic [DW-1:0] sram_data_out,
   output logic          sram_data_oe,
   output logic [15:0]   wr_count,
   output logic [15:0]   rd_count,
   output logic          conflict
);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;

   // Upper address bits alias onto the implemented memory, so only the low
   // MEM_AW bits are worth synchronizing.
   logic addr_hi_unused;
   assign addr_hi_unused = ^sram_addr[AW-1:MEM_AW];

   logic [SYNC_STAGES-1:0][MEM_AW-1:0] addr_sync_q, addr_sync_d;
   logic [SYNC_STAGES-1:0][DW-1:0]     data_sync_q, data_sync_d;
   logic [SYNC_STAGES-1:0]             cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0]             oe_sync_q, oe_sync_d;
   logic [SYNC_STAGES-1:0]             we_sync_q, we_sync_d;

   logic [MEM_AW-1:0] p_addr_q, p_addr_d;
   logic [DW-1:0]     p_data_q, p_data_d;
   logic              p_we_q, p_we_d;

   state_t            state_q, state_d;
   logic [DW-1:0]     data_out_q, data_out_d;
   logic              data_oe_q, data_oe_d;
   logic [15:0]       wr_count_q, wr_count_d;
   logic [15:0]       rd_count_q, rd_count_d;
   logic              conflict_q, conflict_d;

   logic [DW-1:0]     mem [2**MEM_AW];

   logic [MEM_AW-1:0] s_addr;
   logic [DW-1:0]     s_data;
   logic              s_cs, s_oe, s_we;
   logic              commit;

   assign s_addr = addr_sync_q[SYNC_STAGES-1];
   assign s_data = data_sync_q[SYNC_STAGES-1];
   assign s_cs   = cs_sync_q[SYNC_STAGES-1];
   assign s_oe   = oe_sync_q[SYNC_STAGES-1];
   assign s_we   = we_sync_q[SYNC_STAGES-1];

   // WE rising edge while still selected; the address/data captured on the
   // last WE-low sample are the ones written.
   assign commit = !p_we_q && s_we && !s_cs;

   always_comb begin
      addr_sync_d    = addr_sync_q;
      data_sync_d    = data_sync_q;
      cs_sync_d      = cs_sync_q;
      oe_sync_d      = oe_sync_q;
      we_sync_d      = we_sync_q;
      addr_sync_d[0] = sram_addr[MEM_AW-1:0];
      data_sync_d[0] = sram_data_in;
      cs_sync_d[0]   = sram_cs;
      oe_sync_d[0]   = sram_oe;
      we_sync_d[0]   = sram_we;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         addr_sync_d[i] = addr_sync_q[i-1];
         data_sync_d[i] = data_sync_q[i-1];
         cs_sync_d[i]   = cs_sync_q[i-1];
         oe_sync_d[i]   = oe_sync_q[i-1];
         we_sync_d[i]   = we_sync_q[i-1];
      end
      p_addr_d = s_addr;
      p_data_d = s_data;
      p_we_d   = s_we;
   end

   always_comb begin
      state_d    = ST_IDLE;
      data_out_d = data_out_q;
      data_oe_d  = 1'b0;
      wr_count_d = wr_count_q;
      rd_count_d = rd_count_q;
      conflict_d = conflict_q | (!s_cs && !s_oe && !s_we);

      // WRITE outranks READ, so a CS/OE/WE-all-low conflict never drives the bus.
      if (!s_cs && !s_we) begin
         state_d = ST_WRITE;
      end else if (!s_cs && !s_oe) begin
         state_d = ST_READ;
      end

      if (state_d == ST_READ) begin
         data_out_d = mem[s_addr];
         data_oe_d  = 1'b1;
         if (state_q != ST_READ && rd_count_q != 16'hFFFF) begin
            rd_count_d = rd_count_q + 16'd1;
         end
      end

      if (commit && wr_count_q != 16'hFFFF) begin
         wr_count_d = wr_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_sync_q <= '0;
         data_sync_q <= '0;
         cs_sync_q   <= '1;
         oe_sync_q   <= '1;
         we_sync_q   <= '1;
         p_addr_q    <= '0;
         p_data_q    <= '0;
         p_we_q      <= 1'b1;
         state_q     <= ST_IDLE;
         data_out_q  <= '0;
         data_oe_q   <= 1'b0;
         wr_count_q  <= '0;
         rd_count_q  <= '0;
         conflict_q  <= 1'b0;
      end else begin
         addr_sync_q <= addr_sync_d;
         data_sync_q <= data_sync_d;
         cs_sync_q   <= cs_sync_d;
         oe_sync_q   <= oe_sync_d;
         we_sync_q   <= we_sync_d;
         p_addr_q    <= p_addr_d;
         p_data_q    <= p_data_d;
         p_we_q      <= p_we_d;
         state_q     <= state_d;
         data_out_q  <= data_out_d;
         data_oe_q   <= data_oe_d;
         wr_count_q  <= wr_count_d;
         rd_count_q  <= rd_count_d;
         conflict_q  <= conflict_d;
      end
   end

   // Memory is never cleared; a write pending when reset asserts is dropped.
   always_ff @(posedge clk) begin
      if (rst_n && commit) begin
         mem[p_addr_q] <= p_data_q;
      end
   end

   assign sram_data_out = data_out_q;
   assign sram_data_oe  = data_oe_q;
   assign wr_count      = wr_count_q;
   assign rd_count      = rd_count_q;
   assign conflict      = conflict_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed pin-level bench for sram_responder.
// Latency: checks read data valid exactly 3 clocks after OE falls.
// Backpressure: n/a; the bench plays the SRAM initiator with phases of 4-5 clocks.
module tb_sram_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [17:0] sram_addr;
   logic [15:0] sram_data_in;
   logic        sram_cs, sram_oe, sram_we;
   logic [15:0] sram_data_out;
   logic        sram_data_oe;
   logic [15:0] wr_count, rd_count;
   logic        conflict;

   int checks   = 0;
   int failures = 0;
   logic [15:0] rd_model = 16'd0;

   typedef struct {
      int          kind;      // 0 write, 1 WE pulse with CS high, 2 read
      logic [17:0] addr;
      logic [15:0] data;
      logic [15:0] exp_data;
      logic [15:0] exp_wr;
   } vec_t;

   vec_t vecs[10];

   sram_responder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sram_addr    (sram_addr),
      .sram_data_in (sram_data_in),
      .sram_cs      (sram_cs),
      .sram_oe      (sram_oe),
      .sram_we      (sram_we),
      .sram_data_out(sram_data_out),
      .sram_data_oe (sram_data_oe),
      .wr_count     (wr_count),
      .rd_count     (rd_count),
      .conflict     (conflict)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic write_op(input logic [17:0] addr, input logic [15:0] data, input logic cs_lvl);
      sram_addr    = addr;
      sram_data_in = data;
      sram_cs      = cs_lvl;
      sram_oe      = 1'b1;
      tick(4);
      sram_we = 1'b0;
      tick(5);
      sram_we = 1'b1;
      tick(4);
      sram_cs = 1'b1;
      tick(4);
   endtask

   task automatic read_op(input logic [17:0] addr, input logic [15:0] exp);
      sram_addr = addr;
      sram_cs   = 1'b0;
      sram_we   = 1'b1;
      tick(4);
      sram_oe = 1'b0;
      tick(2);
      check("rd_oe_early", sram_data_oe, 1'b0);
      tick(1);
      check("rd_oe_valid", sram_data_oe, 1'b1);
      check("rd_data", sram_data_out, exp);
      rd_model = sat_inc(rd_model);
      check("rd_count", rd_count, rd_model);
      sram_oe = 1'b1;
      tick(4);
      check("rd_oe_drop", sram_data_oe, 1'b0);
      sram_cs = 1'b1;
      tick(4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0, 18'h0545D, 16'hDEAD, 16'h0000, 16'd1};
      vecs[1] = '{2, 18'h0545D, 16'h0000, 16'hDEAD, 16'd1};
      vecs[2] = '{0, 18'h3ACB4, 16'hBEEF, 16'h0000, 16'd2};
      vecs[3] = '{2, 18'h000B4, 16'h0000, 16'hBEEF, 16'd2};
      vecs[4] = '{2, 18'h0545D, 16'h0000, 16'hDEAD, 16'd2};
      vecs[5] = '{1, 18'h0005D, 16'h1234, 16'h0000, 16'd2};
      vecs[6] = '{2, 18'h0005D, 16'h0000, 16'hDEAD, 16'd2};
      vecs[7] = '{0, 18'h00001, 16'hA5A5, 16'h0000, 16'd3};
      vecs[8] = '{2, 18'h20101, 16'h0000, 16'hA5A5, 16'd3};
      vecs[9] = '{2, 18'h3ACB4, 16'h0000, 16'hBEEF, 16'd3};

      rst_n        = 1'b0;
      sram_addr    = '0;
      sram_data_in = '0;
      sram_cs      = 1'b1;
      sram_oe      = 1'b1;
      sram_we      = 1'b1;
      tick(2);
      check("reset_data_out", sram_data_out, 16'h0000);
      check("reset_data_oe", sram_data_oe, 1'b0);
      check("reset_wr_count", wr_count, 16'h0000);
      check("reset_rd_count", rd_count, 16'h0000);
      check("reset_conflict", conflict, 1'b0);
      rst_n = 1'b1;
      tick(2);

      for (int i = 0; i < 10; i++) begin
         case (vecs[i].kind)
            0:       write_op(vecs[i].addr, vecs[i].data, 1'b0);
            1:       write_op(vecs[i].addr, vecs[i].data, 1'b1);
            default: read_op(vecs[i].addr, vecs[i].exp_data);
         endcase
         check("vec_wr_count", wr_count, vecs[i].exp_wr);
      end

      // Address change while OE stays low: new word follows 3 clocks later.
      sram_addr = 18'h0005D;
      sram_cs   = 1'b0;
      tick(4);
      sram_oe = 1'b0;
      tick(3);
      check("chg_first_data", sram_data_out, 16'hDEAD);
      sram_addr = 18'h000B4;
      tick(2);
      check("chg_old_data", sram_data_out, 16'hDEAD);
      tick(1);
      check("chg_new_data", sram_data_out, 16'hBEEF);
      rd_model = sat_inc(rd_model);
      check("chg_rd_count", rd_count, rd_model);
      sram_oe = 1'b1;
      tick(2);
      check("leave_oe_hold", sram_data_oe, 1'b1);
      tick(1);
      check("leave_oe_drop", sram_data_oe, 1'b0);
      check("leave_data_hold", sram_data_out, 16'hBEEF);
      sram_cs = 1'b1;
      tick(4);

      // CS/OE/WE all low: write wins, bus never driven, conflict sticks.
      // Releasing CS together with WE must not commit.
      begin
         int oe_seen;
         oe_seen      = 0;
         sram_addr    = 18'h00077;
         sram_data_in = 16'h7777;
         sram_cs      = 1'b0;
         sram_oe      = 1'b0;
         sram_we      = 1'b0;
         for (int i = 0; i < 6; i++) begin
            tick(1);
            if (sram_data_oe) oe_seen++;
         end
         check("conflict_oe_low", oe_seen, 0);
         check("conflict_set", conflict, 1'b1);
         sram_cs = 1'b1;
         sram_oe = 1'b1;
         sram_we = 1'b1;
         tick(6);
         check("conflict_sticky", conflict, 1'b1);
         check("conflict_no_commit", wr_count, 16'd3);
         check("conflict_rd_count", rd_count, rd_model);
      end

      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("rst2_conflict", conflict, 1'b0);
      check("rst2_wr_count", wr_count, 16'h0000);
      check("rst2_rd_count", rd_count, 16'h0000);
      check("rst2_data_oe", sram_data_oe, 1'b0);
      check("rst2_data_out", sram_data_out, 16'h0000);
      rd_model = 16'd0;
      tick(2);

      // Reset mid-write; WE rises as reset releases, so nothing may commit.
      sram_addr    = 18'h0005D;
      sram_data_in = 16'h4321;
      sram_cs      = 1'b0;
      tick(4);
      sram_we = 1'b0;
      tick(5);
      rst_n = 1'b0;
      tick(1);
      rst_n   = 1'b1;
      sram_we = 1'b1;
      tick(6);
      check("midrst_wr_count", wr_count, 16'h0000);
      sram_cs = 1'b1;
      tick(4);
      read_op(18'h0545D, 16'hDEAD);
      check("midrst_wr_after", wr_count, 16'h0000);

      // Saturation: preload the read counter near the top, then keep entering READ.
      sram_addr = 18'h0005D;
      sram_cs   = 1'b0;
      sram_oe   = 1'b1;
      sram_we   = 1'b1;
      tick(4);
      force dut.rd_count_q = 16'hFFFC;
      #1;
      release dut.rd_count_q;
      rd_model = 16'hFFFC;
      for (int i = 0; i < 5; i++) begin
         sram_oe = 1'b0;
         tick(3);
         sram_oe = 1'b1;
         tick(3);
         rd_model = sat_inc(rd_model);
         check("sat_rd_count", rd_count, rd_model);
      end
      sram_cs = 1'b1;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
